// File: rtl/press_pulse_gen.sv
// Debounced pushbutton to single-cycle press strobe, with optional auto-repeat
// while held (enabled by defining PRESS_PULSE_GEN_AUTO_REPEAT_EN).
module press_pulse_gen #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic        BTN_ACTIVE_LOW  = 1'b1,
  parameter logic [23:0] REPEAT_DELAY    = 24'd10000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse,
  output logic pressed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        btn_norm;
  logic        sync1;
  logic        sync;
  logic [15:0] count;
  logic [15:0] count_next;
  logic        pulse_next;

`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
  logic [23:0] rpt_timer;
  logic [23:0] rpt_timer_next;
  logic        rpt_armed;
  logic        rpt_armed_next;
  logic [23:0] rpt_limit;

  // The first repeat waits the long delay; later ones use the shorter period.
  assign rpt_limit = rpt_armed ? REPEAT_PERIOD : REPEAT_DELAY;
`else
  // Repeat parameters have no effect when auto-repeat is compiled out.
  if ((REPEAT_DELAY == 24'd0) && (REPEAT_PERIOD == 24'd0)) begin : g_repeat_unused
  end
`endif

  assign btn_norm = BTN_ACTIVE_LOW ? ~btn : btn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync  <= 1'b0;
    end else begin
      sync1 <= btn_norm;
      sync  <= sync1;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    pulse_next = 1'b0;
`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
    rpt_timer_next = rpt_timer;
    rpt_armed_next = rpt_armed;
`endif
    case (state)
      IDLE: begin
        if (sync) begin
          state_next = PRESS_WAIT;
          count_next = 16'd0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_next = IDLE;
        end else if (count == DEBOUNCE_CYCLES - 16'd1) begin
          state_next = HELD;
          pulse_next = 1'b1;
`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
          rpt_timer_next = 24'd0;
          rpt_armed_next = 1'b0;
`endif
        end else begin
          count_next = count + 16'd1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_next = RELEASE_WAIT;
          count_next = 16'd0;
        end
`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
        else if (rpt_timer == rpt_limit - 24'd1) begin
          pulse_next     = 1'b1;
          rpt_timer_next = 24'd0;
          rpt_armed_next = 1'b1;
        end else begin
          rpt_timer_next = rpt_timer + 24'd1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_next = HELD;
        end else if (count == DEBOUNCE_CYCLES - 16'd1) begin
          state_next = IDLE;
        end else begin
          count_next = count + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 16'd0;
      end
    endcase
  end

  // pressed is derived from the next state so it lines up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 16'd0;
      pulse   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pulse   <= pulse_next;
      pressed <= (state_next == HELD) || (state_next == RELEASE_WAIT);
    end
  end

`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_timer <= 24'd0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_timer <= rpt_timer_next;
      rpt_armed <= rpt_armed_next;
    end
  end
`endif

endmodule

// File: tb/tb_press_pulse_gen.sv
// Scoreboard bench for press_pulse_gen: stimulus pushes expected pulse cycles,
// a negedge monitor pops and compares them as pulses appear.
module tb_press_pulse_gen;

  logic clk;
  logic reset;
  logic btn;
  logic pulse;
  logic pressed;

  int cyc = 0;
  int assertions = 0;
  int failures = 0;
  int expq[$];

  logic       loadCount = 1'b0;
  logic [5:0] dcount;

  press_pulse_gen #(
    .DEBOUNCE_CYCLES(16'd4),
    .BTN_ACTIVE_LOW (1'b1),
    .REPEAT_DELAY   (24'd10),
    .REPEAT_PERIOD  (24'd5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .pulse  (pulse),
    .pressed(pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 6-bit decrementer fed directly by pulse.
  always @(posedge clk) begin
    if (loadCount) dcount <= 6'd63;
    else if (pulse === 1'b1) dcount <= dcount - 6'd1;
  end

  // Monitor: flags overdue expectations, then matches each observed pulse.
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0] < cyc) begin
      assertions++;
      failures++;
      $display("[TB] FAIL pulse_missing: no pulse seen, required at cycle %0d (now %0d)", expq[0], cyc);
      void'(expq.pop_front());
    end
    if (pulse === 1'b1) begin
      assertions++;
      if (expq.size() == 0) begin
        failures++;
        $display("[TB] FAIL pulse_unexpected: pulse at cycle %0d, required none", cyc);
      end else if (expq[0] != cyc) begin
        failures++;
        $display("[TB] FAIL pulse_timing: pulse at cycle %0d, required cycle %0d", cyc, expq[0]);
        void'(expq.pop_front());
      end else begin
        void'(expq.pop_front());
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    btn = level;
    waitCycles(cycles);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectPulse(input int c);
    expq.push_back(c);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    btn   = 1'b1;
    waitCycles(3);
    checkOutput("reset_pulse", {31'd0, pulse}, 32'd0);
    checkOutput("reset_pressed", {31'd0, pressed}, 32'd0);
    reset = 1'b0;
    waitCycles(5);
    checkOutput("idle_pressed", {31'd0, pressed}, 32'd0);

    $display("[TB] clean press and release");
    n = cyc;
    expectPulse(n + 7);
`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
    expectPulse(n + 17);
    expectPulse(n + 22);
`endif
    applyStimulus(1'b0, 6);
    checkOutput("press_pressed_before", {31'd0, pressed}, 32'd0);
    waitCycles(1);
    checkOutput("press_pressed_edge7", {31'd0, pressed}, 32'd1);
    waitCycles(13);
    applyStimulus(1'b1, 6);
    checkOutput("release_pressed_hold", {31'd0, pressed}, 32'd1);
    waitCycles(1);
    checkOutput("release_pressed_drop", {31'd0, pressed}, 32'd0);
    waitCycles(5);

    $display("[TB] bounce rejection");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3);
      applyStimulus(1'b1, 1);
      checkOutput("bounce_pressed", {31'd0, pressed}, 32'd0);
    end
    applyStimulus(1'b1, 8);

    $display("[TB] glitch while held");
    n = cyc;
    expectPulse(n + 7);
    applyStimulus(1'b0, 8);
    for (int k = 8; k <= 20; k++) begin
      checkOutput("glitch_pressed", {31'd0, pressed}, 32'd1);
      btn = (k == 9 || k == 10 || k >= 14) ? 1'b1 : 1'b0;
      waitCycles(1);
    end
    checkOutput("glitch_release_pressed", {31'd0, pressed}, 32'd0);
    waitCycles(5);

    $display("[TB] reset during press wait");
    n = cyc;
    applyStimulus(1'b0, 4);
    reset = 1'b1;
    #1;
    checkOutput("midreset_pulse", {31'd0, pulse}, 32'd0);
    checkOutput("midreset_pressed", {31'd0, pressed}, 32'd0);
    waitCycles(2);
    reset = 1'b0;
    n = cyc;
    expectPulse(n + 7);
    waitCycles(6);
    checkOutput("postreset_pressed_before", {31'd0, pressed}, 32'd0);
    waitCycles(1);
    checkOutput("postreset_pressed", {31'd0, pressed}, 32'd1);
    waitCycles(3);
    applyStimulus(1'b1, 12);
    checkOutput("postreset_release", {31'd0, pressed}, 32'd0);

    $display("[TB] long hold");
    n = cyc;
    expectPulse(n + 7);
`ifdef PRESS_PULSE_GEN_AUTO_REPEAT_EN
    for (int r = 10; r <= 30; r += 5) expectPulse(n + 7 + r);
`endif
    applyStimulus(1'b0, 37);
    checkOutput("long_hold_pressed", {31'd0, pressed}, 32'd1);
    applyStimulus(1'b1, 12);
    checkOutput("long_hold_release", {31'd0, pressed}, 32'd0);

    $display("[TB] 63 presses into down-counter");
    loadCount = 1'b1;
    waitCycles(1);
    loadCount = 1'b0;
    for (int p = 0; p < 63; p++) begin
      n = cyc;
      expectPulse(n + 7);
      applyStimulus(1'b0, 9);
      applyStimulus(1'b1, 9);
    end
    waitCycles(5);
    checkOutput("downcounter_value", {26'd0, dcount}, 32'd0);

    waitCycles(10);
    checkOutput("scoreboard_drained", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/press_pulse_gen.md
PRESS_PULSE_GEN -- requirements
Module: press_pulse_gen

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16'd50000, consecutive stable clk cycles required to accept a press or release; legal range 2..65535.
REQ-002 Parameter: BTN_ACTIVE_LOW, 1'b1, 1 = btn pressed when low; 0 = btn pressed when high.
REQ-003 Parameter: REPEAT_DELAY, 24'd10000000, cycles from the press pulse to the first auto-repeat pulse; used only with PRESS_PULSE_GEN_AUTO_REPEAT_EN; legal range >= 2.
REQ-004 Parameter: REPEAT_PERIOD, 24'd2500000, cycles between subsequent auto-repeat pulses; legal range >= 2.
REQ-005 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-006 Port: reset  input  1  reset, asynchronous, active-high.
REQ-007 Port: btn  input  1  raw pushbutton level; asynchronous to clk; may bounce.
REQ-008 Port: pulse  output  1  registered single-cycle strobe per accepted press; drives the downstream decrement input directly.
REQ-009 Port: pressed  output  1  registered debounced button level; 1 = pressed.

Function
REQ-010 btn SHALL be normalised (inverted when BTN_ACTIVE_LOW = 1) and passed through a 2-flop synchroniser; only the synchroniser output (sync) SHALL feed the rest of the logic.
REQ-011 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; a single debounce counter (16 bits) SHALL be shared by both wait states.
REQ-012 IDLE: sync = 1 -> PRESS_WAIT with counter = 0; otherwise stay.
REQ-013 PRESS_WAIT: sync = 0 -> IDLE, no pulse (bounce rejected); sync = 1 and counter = DEBOUNCE_CYCLES-1 -> HELD; otherwise counter +1.
REQ-014 The transition into HELD from PRESS_WAIT SHALL register pulse = 1 for exactly one clk cycle.
REQ-015 Latency: with btn stable-active, number edges from 1 at the first edge sampling it active; pulse SHALL rise on edge DEBOUNCE_CYCLES+3 and fall on the next edge.
REQ-016 HELD: sync = 0 -> RELEASE_WAIT with counter = 0; otherwise stay.
REQ-017 RELEASE_WAIT: sync = 1 -> HELD with no pulse; sync = 0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-018 pressed SHALL be 1 in HELD and RELEASE_WAIT and 0 in IDLE and PRESS_WAIT, registered with the state.
REQ-019 pulse SHALL never be high for two consecutive cycles; a press/release cycle SHALL produce at most one non-repeat pulse.
REQ-020 Bounces shorter than DEBOUNCE_CYCLES during a press or release SHALL produce no additional pulse.

Reset
REQ-021 reset = 1 SHALL asynchronously force state = IDLE, counter = 0, synchroniser flops = 0, repeat timer = 0, pulse = 0, pressed = 0.
REQ-022 Reset mid-operation (any state) SHALL discard all progress; a btn held through reset release SHALL be treated as a new press and produce one pulse per REQ-015.
REQ-023 No pulse SHALL be generated on the cycle reset deasserts.

Configuration
REQ-024 Macro PRESS_PULSE_GEN_AUTO_REPEAT_EN defined: a 24-bit repeat timer SHALL count cycles in HELD, clear on entry to HELD from PRESS_WAIT, and hold its value in RELEASE_WAIT.
REQ-025 With the macro defined: an additional one-cycle pulse SHALL occur REPEAT_DELAY cycles after the press pulse and then every REPEAT_PERIOD cycles while in HELD.
REQ-026 Macro undefined: no repeat timer SHALL be synthesised; exactly one pulse per accepted press; REPEAT_DELAY/REPEAT_PERIOD SHALL be ignored.

Verification (DEBOUNCE_CYCLES = 4, BTN_ACTIVE_LOW = 1 unless stated)
REQ-027 btn low for 20 cycles then high -> exactly one pulse, rising on edge 7; pressed = 1 from edge 7 until 4 stable-high cycles after release (+2 sync).
REQ-028 btn low 3 cycles / high 1 cycle repeated 10 times -> no pulse; pressed stays 0.
REQ-029 Held press with a 2-cycle high glitch -> no extra pulse; pressed stays 1.
REQ-030 reset pulsed while in PRESS_WAIT with btn held low -> pulse/pressed 0 immediately; after release one pulse on edge 7 counted from the first post-reset sample.
REQ-031 Macro defined, REPEAT_DELAY = 10, REPEAT_PERIOD = 5, btn held 30 cycles past the press pulse -> repeat pulses at +10, +15, +20, +25, +30; macro undefined -> press pulse only.
REQ-032 63 clean presses feeding the downstream 6-bit down-counter from 63 -> counter reads 0, with no missing or duplicate decrements.
